// File: rtl/mem_wb_stage_if.sv
// Bundles for the memory/writeback stage: the execute-side handshake and
// the data-memory request bus.

// Execute -> mem/wb handshake. The execute stage is master.
interface ex_mem_if #(
  parameter int word_size     = 32,
  parameter int address_width = 5
);
  logic                     ex_valid;
  logic                     ex_ready;
  logic                     ex_is_load;
  logic                     ex_is_store;
  logic                     ex_reg_write;
  logic [2:0]               ex_funct3;
  logic [word_size-1:0]     ex_addr;
  logic [word_size-1:0]     ex_store_data;
  logic [word_size-1:0]     ex_alu_result;
  logic [address_width-1:0] ex_rd;

  modport master (
    output ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3,
           ex_addr, ex_store_data, ex_alu_result, ex_rd,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_is_load, ex_is_store, ex_reg_write, ex_funct3,
           ex_addr, ex_store_data, ex_alu_result, ex_rd,
    output ex_ready
  );
endinterface

// Data-memory req/ack bus. The mem/wb stage is master.
interface dmem_if #(
  parameter int word_size = 32
);
  logic                 dm_req;
  logic                 dm_we;
  logic [word_size-1:0] dm_addr;
  logic [word_size-1:0] dm_wdata;
  logic [3:0]           dm_wstrb;
  logic                 dm_ack;
  logic [word_size-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage. Retires one instruction at a time,
// runs loads/stores over the req/ack data-memory bus with byte-lane
// alignment, and drives the register-file write port.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a new instruction; ALU results retire here
// MEM_WAIT | memory request outstanding, dm_* held, upstream stalled

module mem_wb_stage #(
  parameter int word_size     = 32,
  parameter int address_width = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ex_mem_if.slave                  ex,
  dmem_if.master                   dm,
  output logic                     we3,
  output logic [address_width-1:0] wr_addr3,
  output logic [word_size-1:0]     wr_data3,
  output logic                     mem_fault
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t state, state_nxt;

  logic                     accept;
  logic                     is_mem;
  logic                     illegal_f3;
  logic                     misaligned;
  logic                     fault;
  logic [word_size-1:0]     st_wdata;
  logic [3:0]               st_wstrb;
  logic [2:0]               f3_q;
  logic [1:0]               lane_q;
  logic [address_width-1:0] rd_q;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [word_size-1:0]     ld_value;

  assign accept = ex.ex_valid & ex.ex_ready;
  assign is_mem = ex.ex_is_load | ex.ex_is_store;

  // Decode illegal size codes and misalignment for the presented memory op.
  always_comb begin
    illegal_f3 = (ex.ex_funct3 == 3'b011) || (ex.ex_funct3 == 3'b110) ||
                 (ex.ex_funct3 == 3'b111);
    misaligned = ((ex.ex_funct3[1:0] == 2'b01) && ex.ex_addr[0]) ||
                 ((ex.ex_funct3[1:0] == 2'b10) && (ex.ex_addr[1:0] != 2'b00));
    fault      = is_mem & (illegal_f3 | misaligned);
  end

  // Replicate store data across lanes and pick byte enables from the offset.
  always_comb begin
    st_wdata = ex.ex_store_data;
    st_wstrb = 4'b1111;
    case (ex.ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex.ex_store_data[7:0]}};
        st_wstrb = 4'b0001 << ex.ex_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{ex.ex_store_data[15:0]}};
        st_wstrb = ex.ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = ex.ex_store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    ld_value = dm.dm_rdata;
    case (lane_q)
      2'd0:    ld_byte = dm.dm_rdata[7:0];
      2'd1:    ld_byte = dm.dm_rdata[15:8];
      2'd2:    ld_byte = dm.dm_rdata[23:16];
      default: ld_byte = dm.dm_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (f3_q)
      3'b000:  ld_value = {{(word_size-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {{(word_size-8){1'b0}}, ld_byte};
      3'b001:  ld_value = {{(word_size-16){ld_half[15]}}, ld_half};
      3'b101:  ld_value = {{(word_size-16){1'b0}}, ld_half};
      default: ld_value = dm.dm_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and ready; ready depends on state only so it never loops back
  // through ex_valid.
  always_comb begin
    state_nxt   = state;
    ex.ex_ready = 1'b0;
    case (state)
      IDLE: begin
        ex.ex_ready = 1'b1;
        if (ex.ex_valid && is_mem && !fault) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dm.dm_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory bus, captured op context and writeback/fault pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= '0;
      dm.dm_wdata <= '0;
      dm.dm_wstrb <= 4'b0000;
      f3_q        <= 3'b000;
      lane_q      <= 2'b00;
      rd_q        <= '0;
      we3         <= 1'b0;
      wr_addr3    <= '0;
      wr_data3    <= '0;
      mem_fault   <= 1'b0;
    end else begin
      we3       <= 1'b0;
      mem_fault <= 1'b0;
      if (state == IDLE && accept) begin
        if (!is_mem) begin
          we3      <= ex.ex_reg_write & (ex.ex_rd != '0);
          wr_addr3 <= ex.ex_rd;
          wr_data3 <= ex.ex_alu_result;
        end else if (fault) begin
          mem_fault <= 1'b1;
        end else begin
          dm.dm_req   <= 1'b1;
          dm.dm_we    <= ex.ex_is_store;
          dm.dm_addr  <= {ex.ex_addr[word_size-1:2], 2'b00};
          dm.dm_wdata <= st_wdata;
          dm.dm_wstrb <= st_wstrb;
          f3_q        <= ex.ex_funct3;
          lane_q      <= ex.ex_addr[1:0];
          rd_q        <= ex.ex_rd;
        end
      end else if (state == MEM_WAIT && dm.dm_ack) begin
        dm.dm_req <= 1'b0;
        if (!dm.dm_we) begin
          we3      <= (rd_q != '0);
          wr_addr3 <= rd_q;
          wr_data3 <= ld_value;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: ALU retire, loads with extension,
// stores with lane formatting, faults and reset during an access.

module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        we3;
  logic [4:0]  wr_addr3;
  logic [31:0] wr_data3;
  logic        mem_fault;

  int total = 0;
  int bad   = 0;

  ex_mem_if #(.word_size(32), .address_width(5)) exi ();
  dmem_if   #(.word_size(32))                    dmi ();

  mem_wb_stage #(.word_size(32), .address_width(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex        (exi),
    .dm        (dmi),
    .we3       (we3),
    .wr_addr3  (wr_addr3),
    .wr_data3  (wr_data3),
    .mem_fault (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic ld, input logic st, input logic rw,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] alu,
                          input logic [4:0] rd);
    exi.ex_valid      = 1'b1;
    exi.ex_is_load    = ld;
    exi.ex_is_store   = st;
    exi.ex_reg_write  = rw;
    exi.ex_funct3     = f3;
    exi.ex_addr       = addr;
    exi.ex_store_data = sd;
    exi.ex_alu_result = alu;
    exi.ex_rd         = rd;
  endtask

  task automatic clear_ex();
    exi.ex_valid    = 1'b0;
    exi.ex_is_load  = 1'b0;
    exi.ex_is_store = 1'b0;
  endtask

  // One load or store; ack arrives delay cycles after the first request cycle.
  task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input int delay, input logic [31:0] exp_addr,
                        input logic [31:0] exp_val, input logic [3:0] exp_strb,
                        input logic exp_we3);
    int lows;
    @(negedge clk);
    drive_ex(ld, !ld, ld, f3, addr, sd, 32'h0, rd);
    chk({tag, "_rdy_in"}, {31'h0, exi.ex_ready}, 32'h1);
    @(negedge clk);
    clear_ex();
    chk({tag, "_we"},   {31'h0, dmi.dm_we}, {31'h0, !ld});
    chk({tag, "_addr"}, dmi.dm_addr, exp_addr);
    if (!ld) begin
      chk({tag, "_wdata"}, dmi.dm_wdata, exp_val);
      chk({tag, "_wstrb"}, {28'h0, dmi.dm_wstrb}, {28'h0, exp_strb});
    end
    lows = 0;
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) @(negedge clk);
      if (!exi.ex_ready) lows++;
      chk({tag, "_req"}, {31'h0, dmi.dm_req}, 32'h1);
    end
    chk({tag, "_addr_hold"}, dmi.dm_addr, exp_addr);
    dmi.dm_ack   = 1'b1;
    dmi.dm_rdata = rdata;
    @(negedge clk);
    dmi.dm_ack   = 1'b0;
    dmi.dm_rdata = 32'h0;
    chk({tag, "_stall_len"}, lows, delay + 1);
    chk({tag, "_req_drop"}, {31'h0, dmi.dm_req}, 32'h0);
    chk({tag, "_rdy_out"}, {31'h0, exi.ex_ready}, 32'h1);
    chk({tag, "_we3"}, {31'h0, we3}, {31'h0, exp_we3});
    if (ld && exp_we3) begin
      chk({tag, "_wa"}, {27'h0, wr_addr3}, {27'h0, rd});
      chk({tag, "_wd"}, wr_data3, exp_val);
    end
    @(negedge clk);
    chk({tag, "_we3_pulse"}, {31'h0, we3}, 32'h0);
  endtask

  task automatic fault_op(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, f3, addr, 32'h0, 32'h0, 5'd6);
    @(negedge clk);
    clear_ex();
    chk({tag, "_fault"}, {31'h0, mem_fault}, 32'h1);
    chk({tag, "_req"},   {31'h0, dmi.dm_req}, 32'h0);
    chk({tag, "_we3"},   {31'h0, we3}, 32'h0);
    chk({tag, "_rdy"},   {31'h0, exi.ex_ready}, 32'h1);
    @(negedge clk);
    chk({tag, "_fault_pulse"}, {31'h0, mem_fault}, 32'h0);
    chk({tag, "_req2"},  {31'h0, dmi.dm_req}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_ex();
    exi.ex_reg_write  = 1'b0;
    exi.ex_funct3     = 3'b000;
    exi.ex_addr       = 32'h0;
    exi.ex_store_data = 32'h0;
    exi.ex_alu_result = 32'h0;
    exi.ex_rd         = 5'd0;
    dmi.dm_ack        = 1'b0;
    dmi.dm_rdata      = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req",   {31'h0, dmi.dm_req}, 32'h0);
    chk("rst_we3",   {31'h0, we3}, 32'h0);
    chk("rst_fault", {31'h0, mem_fault}, 32'h0);
    chk("rst_addr",  dmi.dm_addr, 32'h0);
    chk("rst_rdy",   {31'h0, exi.ex_ready}, 32'h1);
    rst_n = 1'b1;

    // ALU retire
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 5'd5);
    @(negedge clk);
    clear_ex();
    chk("alu_we3", {31'h0, we3}, 32'h1);
    chk("alu_wa",  {27'h0, wr_addr3}, 32'd5);
    chk("alu_wd",  wr_data3, 32'h1234_5678);
    @(negedge clk);
    chk("alu_pulse", {31'h0, we3}, 32'h0);

    // ALU to x0 never writes
    drive_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'hCAFE_0000, 5'd0);
    @(negedge clk);
    clear_ex();
    chk("alu_x0_we3", {31'h0, we3}, 32'h0);

    // Back-to-back ALU ops, one per cycle
    drive_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_00A1, 5'd3);
    @(negedge clk);
    chk("tp1_we3", {31'h0, we3}, 32'h1);
    chk("tp1_wd",  wr_data3, 32'h0000_00A1);
    drive_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_00B2, 5'd4);
    @(negedge clk);
    clear_ex();
    chk("tp2_we3", {31'h0, we3}, 32'h1);
    chk("tp2_wa",  {27'h0, wr_addr3}, 32'd4);
    chk("tp2_wd",  wr_data3, 32'h0000_00B2);

    // Loads: sign/zero extension across lanes
    mem_op("lb",  1'b1, 3'b000, 32'h103, 32'h0, 32'h80AA_BBCC, 5'd7, 3, 32'h100, 32'hFFFF_FF80, 4'h0, 1'b1);
    mem_op("lbu", 1'b1, 3'b100, 32'h103, 32'h0, 32'h80AA_BBCC, 5'd7, 3, 32'h100, 32'h0000_0080, 4'h0, 1'b1);
    mem_op("lhu", 1'b1, 3'b101, 32'h202, 32'h0, 32'hBEEF_0001, 5'd8, 0, 32'h200, 32'h0000_BEEF, 4'h0, 1'b1);
    mem_op("lh",  1'b1, 3'b001, 32'h202, 32'h0, 32'hBEEF_0001, 5'd8, 0, 32'h200, 32'hFFFF_BEEF, 4'h0, 1'b1);
    mem_op("lb1", 1'b1, 3'b000, 32'h101, 32'h0, 32'h1234_7F00, 5'd9, 1, 32'h100, 32'h0000_007F, 4'h0, 1'b1);
    mem_op("lw",  1'b1, 3'b010, 32'h304, 32'h0, 32'hDEAD_BEEF, 5'd2, 2, 32'h304, 32'hDEAD_BEEF, 4'h0, 1'b1);
    mem_op("lbx0",1'b1, 3'b000, 32'h100, 32'h0, 32'h0000_0055, 5'd0, 0, 32'h100, 32'h0, 4'h0, 1'b0);

    // Stores: lane replication and byte enables, never a writeback
    mem_op("sb", 1'b0, 3'b000, 32'h41, 32'h0000_00A5, 32'h0, 5'd1, 1, 32'h40, 32'hA5A5_A5A5, 4'b0010, 1'b0);
    mem_op("sh", 1'b0, 3'b001, 32'h42, 32'h1234_BEEF, 32'h0, 5'd1, 0, 32'h40, 32'hBEEF_BEEF, 4'b1100, 1'b0);
    mem_op("sw", 1'b0, 3'b010, 32'h80, 32'hDEAD_BEEF, 32'h0, 5'd1, 2, 32'h80, 32'hDEAD_BEEF, 4'b1111, 1'b0);

    // Faults
    fault_op("flw", 3'b010, 32'h6);
    fault_op("ff3", 3'b011, 32'h0);
    fault_op("flh", 3'b001, 32'h201);

    // Load then ALU op accepted in the cycle after the load writes back
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    clear_ex();
    dmi.dm_ack   = 1'b1;
    dmi.dm_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    dmi.dm_ack   = 1'b0;
    chk("b2b_ld_we3", {31'h0, we3}, 32'h1);
    chk("b2b_ld_wd",  wr_data3, 32'h0BAD_F00D);
    drive_ex(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_0055, 5'd10);
    @(negedge clk);
    clear_ex();
    chk("b2b_alu_we3", {31'h0, we3}, 32'h1);
    chk("b2b_alu_wa",  {27'h0, wr_addr3}, 32'd10);
    chk("b2b_alu_wd",  wr_data3, 32'h0000_0055);

    // Reset while a load is outstanding
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 5'd11);
    @(negedge clk);
    clear_ex();
    chk("rw_req", {31'h0, dmi.dm_req}, 32'h1);
    chk("rw_rdy", {31'h0, exi.ex_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_drop", {31'h0, dmi.dm_req}, 32'h0);
    chk("rw_rdy_rst",  {31'h0, exi.ex_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    dmi.dm_ack   = 1'b1;
    dmi.dm_rdata = 32'h1111_2222;
    @(negedge clk);
    dmi.dm_ack = 1'b0;
    chk("rw_late_we3", {31'h0, we3}, 32'h0);
    chk("rw_late_req", {31'h0, dmi.dm_req}, 32'h0);
    chk("rw_late_rdy", {31'h0, exi.ex_ready}, 32'h1);
    @(negedge clk);
    chk("rw_late_we3b", {31'h0, we3}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the 5-stage pipeline. Accepts one retiring instruction at a time from the execute stage. Performs any load or store against data memory through a req/ack handshake, with byte-lane alignment and load sign/zero extension. Drives the register-file write port (we3/wr_addr3/wr_data3) and stalls upstream via ex_ready while a memory access is outstanding.

## Interface
- word_size, 32, data/address width
- address_width, 5, register index width

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept; transfer when ex_valid & ex_ready at posedge
- ex_is_load / ex_is_store  in  1  memory op type; at most one set
- ex_reg_write  in  1  instruction writes rd
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  word_size  effective address (loads/stores)
- ex_store_data  in  word_size  rs2 value for stores
- ex_alu_result  in  word_size  writeback value for non-memory ops
- ex_rd  in  address_width  destination register
- dm_req  out  1  memory request, held until ack
- dm_we  out  1  1 = store
- dm_addr  out  word_size  {ex_addr[31:2],2'b00}
- dm_wdata  out  word_size  lane-replicated store data
- dm_wstrb  out  4  byte enables
- dm_ack  in  1  memory completes; sampled only while dm_req=1
- dm_rdata  in  word_size  load word, valid with dm_ack
- we3  out  1  register-file write enable
- wr_addr3  out  address_width  register-file write address
- wr_data3  out  word_size  register-file write data
- mem_fault  out  1  one-cycle pulse: misaligned or illegal funct3

## Operation
- States: IDLE, MEM_WAIT. ex_ready = (state==IDLE), combinational from state only.
- IDLE, accepted non-memory op: next cycle we3 = ex_reg_write & (ex_rd!=0), wr_addr3 = ex_rd, wr_data3 = ex_alu_result; stay IDLE.
- IDLE, accepted memory op, legal and aligned: register dm_addr, dm_we, dm_wdata, dm_wstrb, funct3, addr[1:0], rd. Set dm_req=1 and go to MEM_WAIT.
- Fault: halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 ∈ {011,110,111} on a memory op. Pulse mem_fault next cycle; no dm_req, no we3; stay IDLE.
- MEM_WAIT: all dm_* outputs held stable. On dm_ack: dm_req=0 next cycle; go to IDLE.
  - Store: no writeback.
  - Load: we3 = (rd!=0) next cycle, wr_data3 = extracted value.
- Load extraction:
  - Byte: byte at lane addr[1:0]; LB sign-extends bit 7, LBU zero-extends.
  - Half: lane addr[1] (0 = [15:0], 1 = [31:16]); LH sign-extends, LHU zero-extends.
  - LW: whole word.
- Store formatting:
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = data, wstrb = 1111.
- we3 is a single-cycle pulse per writeback; deasserts the following cycle unless another writeback follows. Write to x0 is never issued.

## Timing
- Reset (async, immediate): state IDLE; dm_req, dm_we, we3, mem_fault = 0; dm_addr, dm_wdata, dm_wstrb, wr_addr3, wr_data3 = 0. Reset during MEM_WAIT abandons the access; dm_req drops without waiting for ack.
- Non-memory op accepted at edge N: we3 high in cycle N+1. Throughput one per cycle.
- Memory op accepted at edge N: dm_req high from N+1 through the cycle in which dm_ack=1 (cycle M, M ≥ N+1; ack in the first cycle is legal).
  - Load: we3 high in cycle M+1.
  - ex_ready low from N+1 through M, high at M+1. An op accepted at M+1 writes back at M+2 (back-to-back we3 legal).
- Register file captures on negedge, so data written in cycle K is readable by decode in the second half of cycle K; no bypass in this block.
- dm_ack while dm_req=0 is ignored.

## Test plan
- ALU op: ex_rd=5, ex_alu_result=0x1234_5678, ex_reg_write=1 → we3=1, wr_addr3=5, wr_data3=0x12345678 one cycle later; ex_rd=0 → we3 stays 0.
- LB addr=0x103, dm_rdata=0x80AA_BBCC, ack after 3 cycles → dm_addr=0x100, ex_ready low 4 cycles, wr_data3=0xFFFF_FF80; LBU same → 0x0000_0080.
- LHU addr=0x202, dm_rdata=0xBEEF_0001, ack in first cycle → wr_data3=0x0000_BEEF; LH → 0xFFFF_BEEF.
- SB addr=0x41, store_data=0x0000_00A5 → dm_we=1, dm_wstrb=0010, dm_wdata=0xA5A5_A5A5, dm_addr=0x40, no we3.
- LW addr=0x6 → mem_fault pulse, dm_req never asserted, we3=0, ex_ready stays 1; funct3=011 load → same.
- rst_n low during MEM_WAIT → dm_req=0 immediately; after release, late dm_ack ignored, ex_ready=1, no we3.
